// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single port of the character data memory
// between the CPU load/store path and the I/O character writer, and adds a
// clear engine that fills every location with CLEAR_CHAR.
//
// Handshake: a requester raises req with addr/data and holds them stable
// until it sees gnt. The grant is combinational in the request cycle, and
// the write commits on the next rising edge. At most one grant per cycle.
// Out-of-range accesses are still granted so they cannot deadlock. Their
// write is suppressed, and addr_err flags them.
module dmem_port_arbiter #(
  parameter int          DEPTH      = 640,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic [7:0]  cpu_rdata,
  input  logic        io_req,
  input  logic [31:0] io_addr,
  input  logic [7:0]  io_wdata,
  output logic        io_gnt,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        addr_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rd
);

  localparam int          CW    = $clog2(DEPTH);
  localparam logic [29:0] LIMIT = 30'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic { IDLE = 1'b0, CLEAR = 1'b1 } state_t;
  // Round-robin owner: who wins the next cycle in which both request.
  localparam logic RR_CPU = 1'b0;
  localparam logic RR_IO  = 1'b1;

  state_t        state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          rr_q, rr_d;
  logic          done_q, done_d;

  logic cpu_ok, io_ok;
  assign cpu_ok = (cpu_addr[31:2] < LIMIT);
  assign io_ok  = (io_addr[31:2]  < LIMIT);

  // Byte-lane bits are ignored; the memory is word-indexed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], io_addr[1:0]};

  // State register, clear counter, round-robin pointer and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      rr_q      <= RR_CPU;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_q      <= rr_d;
      done_q    <= done_d;
    end
  end

  // Next-state, arbitration and memory port muxing.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rr_d      = rr_q;
    done_d    = 1'b0;
    cpu_gnt   = 1'b0;
    io_gnt    = 1'b0;
    cpu_rdata = 8'h00;
    addr_err  = 1'b0;
    mem_we    = 1'b0;
    mem_a     = 32'h0;
    mem_wdata = 8'h00;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          // A clear request wins over any same-cycle access.
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (cpu_req && (!io_req || rr_q == RR_CPU)) begin
          cpu_gnt   = 1'b1;
          mem_a     = {cpu_addr[31:2], 2'b00};
          mem_wdata = cpu_wdata;
          if (cpu_ok) begin
            mem_we = cpu_we;
            if (!cpu_we) cpu_rdata = mem_rd;
          end else begin
            addr_err = 1'b1;
          end
          if (io_req) rr_d = RR_IO;
        end else if (io_req) begin
          io_gnt    = 1'b1;
          mem_a     = {io_addr[31:2], 2'b00};
          mem_wdata = io_wdata;
          if (io_ok) mem_we = 1'b1;
          else       addr_err = 1'b1;
          if (cpu_req) rr_d = RR_CPU;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_a     = 32'({clr_cnt_q, 2'b00});
        mem_wdata = CLEAR_CHAR;
        if (clr_cnt_q == LAST) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_done = done_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a behavioural 640-byte memory on the memory
// port, a reference copy ref_mem, and a queue of expected load data.
module tb_dmem_port_arbiter;

  localparam int DEPTH = 640;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, cpu_gnt;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        io_req, io_gnt;
  logic [31:0] io_addr;
  logic [7:0]  io_wdata;
  logic        clr_start, clr_busy, clr_done, addr_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [7:0]  mem_wdata, mem_rd;

  dmem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_addr(io_addr), .io_wdata(io_wdata), .io_gnt(io_gnt),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .addr_err(addr_err), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; preload fills a pattern that never equals the clear char.
  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];
  logic       preload;
  int         mem_idx;
  assign mem_idx = int'(mem_a[31:2]);
  assign mem_rd  = (mem_a[31:2] < 30'(DEPTH)) ? mem[mem_a[11:2]] : 8'h00;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i) | 8'h80;
    end else if (mem_we && mem_idx < DEPTH) begin
      mem[mem_a[11:2]] <= mem_wdata;
    end
  end

  // Scoreboard.
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(cpu_rdata), 32'(e));
    end
  endtask

  task automatic fill_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i) | 8'h80;
  endtask

  // One CPU access, waiting (bounded) for the grant.
  task automatic cpu_op(input logic we, input int idx, input logic [7:0] d);
    int  t;
    bit  ok;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = 32'(idx) << 2; cpu_wdata = d;
    if (!we) exp_q.push_back(idx < DEPTH ? ref_mem[idx] : 8'h00);
    ok = 0;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cpu_gnt) begin ok = 1; break; end
    end
    check("cpu_gnt_timeout", 32'(ok), 32'd1);
    if (ok) begin
      check("cpu_addr_err", 32'(addr_err), 32'(idx >= DEPTH));
      check("cpu_mem_we", 32'(mem_we), 32'(we && idx < DEPTH));
      check("cpu_mem_a", mem_a, 32'(idx) << 2);
      check("cpu_io_gnt", 32'(io_gnt), 32'd0);
      if (!we) pop_check("cpu_rdata");
      else if (idx < DEPTH) ref_mem[idx] = d;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  // One I/O write, waiting (bounded) for the grant.
  task automatic io_op(input int idx, input logic [7:0] d);
    bit ok;
    @(posedge clk); #1;
    io_req = 1'b1; io_addr = 32'(idx) << 2; io_wdata = d;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (io_gnt) begin ok = 1; break; end
    end
    check("io_gnt_timeout", 32'(ok), 32'd1);
    if (ok) begin
      check("io_addr_err", 32'(addr_err), 32'(idx >= DEPTH));
      check("io_mem_we", 32'(mem_we), 32'(idx < DEPTH));
      check("io_mem_wdata", 32'(mem_wdata), 32'(d));
      if (idx < DEPTH) ref_mem[idx] = d;
    end
    @(posedge clk); #1;
    io_req = 1'b0;
  endtask

  initial begin
    int busy_n, done_n, done_at, bad;
    bit hit;
    rst_n = 1'b0; preload = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    io_req = 0; io_addr = 0; io_wdata = 0; clr_start = 0;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    fill_ref();

    // Reset state.
    @(negedge clk);
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_done", 32'(clr_done), 32'd0);
    check("rst_gnt", 32'({cpu_gnt, io_gnt}), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Store then load at byte address 0x10.
    cpu_op(1'b1, 4, 8'h41);
    cpu_op(1'b0, 4, 8'h00);
    check("store_41", 32'(mem[4]), 32'h41);

    // Boundary indices and out-of-range accesses.
    cpu_op(1'b1, DEPTH - 1, 8'h5a);
    cpu_op(1'b0, DEPTH - 1, 8'h00);
    io_op(DEPTH, 8'h77);
    cpu_op(1'b1, DEPTH, 8'h66);
    cpu_op(1'b0, DEPTH, 8'h00);
    cpu_op(1'b1, 1000, 8'h11);

    // Random mix.
    for (int k = 0; k < 24; k++) begin
      int r, idx;
      r   = $urandom_range(0, 2);
      idx = $urandom_range(0, DEPTH - 1);
      case (r)
        0: cpu_op(1'b1, idx, 8'($urandom_range(0, 255)));
        1: cpu_op(1'b0, idx, 8'h00);
        default: io_op(idx, 8'($urandom_range(0, 255)));
      endcase
    end

    // Both requesting: alternate starting with CPU.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'd5 << 2;
    io_req = 1; io_addr = 32'd6 << 2; io_wdata = 8'h55;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_q.push_back(ref_mem[5]);
      @(negedge clk);
      check("rr_cpu", 32'(cpu_gnt), 32'(k % 2 == 0));
      check("rr_io", 32'(io_gnt), 32'(k % 2 == 1));
      if (cpu_gnt) pop_check("rr_rdata");
      if (io_gnt) begin
        check("rr_io_mem_a", mem_a, 32'd6 << 2);
        ref_mem[6] = 8'h55;
      end
      @(posedge clk);
    end
    #1 cpu_req = 0; io_req = 0;

    // Full clear with a CPU load pending from the start.
    @(posedge clk); #1;
    clr_start = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'd7 << 2;
    exp_q.push_back(8'h20);
    @(negedge clk);
    check("clr_prio_gnt", 32'(cpu_gnt), 32'd0);
    @(posedge clk); #1 clr_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("clr_busy", 32'(clr_busy), 32'd1);
      check("clr_we", 32'(mem_we), 32'd1);
      check("clr_a", mem_a, 32'(i) << 2);
      check("clr_wdata", 32'(mem_wdata), 32'h20);
      check("clr_no_gnt", 32'({cpu_gnt, io_gnt}), 32'd0);
    end
    @(negedge clk);
    check("clr_done_hi", 32'(clr_done), 32'd1);
    check("clr_busy_lo", 32'(clr_busy), 32'd0);
    check("clr_pending_gnt", 32'(cpu_gnt), 32'd1);
    if (cpu_gnt) pop_check("clr_pending_rdata");
    @(posedge clk); #1 cpu_req = 0;
    @(negedge clk);
    check("clr_done_once", 32'(clr_done), 32'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h20;

    // Restart pulse mid-clear is ignored.
    @(posedge clk); #1 clr_start = 1;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (clr_busy) busy_n++;
      if (clr_done) begin done_n++; done_at = c; end
      @(posedge clk); #1;
      clr_start = (c == 100);
    end
    clr_start = 0;
    check("restart_busy_cycles", 32'(busy_n), 32'd640);
    check("restart_done_pulses", 32'(done_n), 32'd1);
    check("restart_done_at", 32'(done_at), 32'd641);

    // Reset in the middle of a clear at index 300.
    preload = 1; @(posedge clk); #1 preload = 0;
    fill_ref();
    clr_start = 1;
    @(posedge clk); #1 clr_start = 0;
    hit = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (clr_busy && mem_a == (32'd300 << 2)) begin hit = 1; break; end
    end
    check("mid_reset_reach_300", 32'(hit), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_busy", 32'(clr_busy), 32'd0);
    check("mid_reset_we", 32'(mem_we), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("mid_reset_no_done", 32'(clr_done), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_idle", 32'({clr_busy, clr_done, mem_we}), 32'd0);
    end
    for (int i = 0; i < 300; i++) ref_mem[i] = 8'h20;
    check("mid_reset_idx299", 32'(mem[299]), 32'h20);
    check("mid_reset_idx300", 32'(mem[300]), 32'(ref_mem[300]));

    // Pointer back to CPU after reset.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'd8 << 2;
    io_req = 1; io_addr = 32'd9 << 2; io_wdata = 8'h33;
    exp_q.push_back(ref_mem[8]);
    @(negedge clk);
    check("rr_after_reset", 32'({cpu_gnt, io_gnt}), 32'b10);
    if (cpu_gnt) pop_check("rr_after_reset_rdata");
    @(posedge clk); #1 cpu_req = 0; io_req = 0;

    // Whole-memory sweep against the reference.
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_sweep", 32'(bad), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
